// File: rtl/rider_steer_en_if.sv
// Load-cell inputs and steering status outputs of the rider-detect / steer-enable block.
// master drives the load readings; slave (the detector) drives the status flags.
interface rider_steer_en_if;
  logic [11:0] lft_ld;
  logic [11:0] rght_ld;
  logic        en_steer;
  logic        rider_off;

  modport master (
    output lft_ld,
    output rght_ld,
    input  en_steer,
    input  rider_off
  );

  modport slave (
    input  lft_ld,
    input  rght_ld,
    output en_steer,
    output rider_off
  );
endinterface

// File: rtl/rider_steer_en.sv
// Rider presence and balance detector: steering is enabled only after the rider
// has stood on the platform, reasonably balanced, for a full balance-timer period.
module rider_steer_en #(
  parameter bit          FAST_SIM      = 1'b0,
  parameter logic [11:0] MIN_RIDER_WT  = 12'h200,
  parameter logic [11:0] WT_HYSTERESIS = 12'h040
) (
  input logic             clk,
  input logic             rst,
  rider_steer_en_if.slave bus
);

  localparam logic [25:0] TMR_MAX  = FAST_SIM ? 26'h0007FFF : 26'h3FFFFFF;
  localparam logic [12:0] ENTER_WT = {1'b0, MIN_RIDER_WT};
  localparam logic [12:0] LEAVE_WT = {1'b0, MIN_RIDER_WT} - {1'b0, WT_HYSTERESIS};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    STEER = 2'd2
  } state_t;

  state_t      state_reg, state_next;
  logic [25:0] timer_reg, timer_next;
  logic        en_steer_reg;
  logic        rider_off_reg;

  logic [12:0] sum;
  logic [11:0] diff;
  logic        sum_gt_min;
  logic        sum_lt_min;
  logic        diff_gt_1_4;
  logic        diff_gt_15_16;

  // Full 13-bit sum so two near-full-scale cells cannot wrap below a threshold.
  always_comb begin
    sum           = {1'b0, bus.lft_ld} + {1'b0, bus.rght_ld};
    diff          = (bus.lft_ld >= bus.rght_ld) ? (bus.lft_ld - bus.rght_ld)
                                                : (bus.rght_ld - bus.lft_ld);
    sum_gt_min    = sum > ENTER_WT;
    sum_lt_min    = sum < LEAVE_WT;
    diff_gt_1_4   = {1'b0, diff} > (sum >> 2);
    diff_gt_15_16 = {1'b0, diff} > (sum - (sum >> 4));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      timer_reg     <= '0;
      rider_off_reg <= 1'b1;
      en_steer_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      timer_reg     <= timer_next;
      rider_off_reg <= (state_next == IDLE);
      en_steer_reg  <= (state_next == STEER);
    end
  end

  // Weight loss is tested first in every state so stepping off always beats imbalance.
  always_comb begin
    state_next = state_reg;
    timer_next = timer_reg;
    case (state_reg)
      IDLE: begin
        if (sum_gt_min) begin
          state_next = WAIT;
          timer_next = '0;
        end
      end
      WAIT: begin
        if (sum_lt_min) begin
          state_next = IDLE;
        end else if (diff_gt_1_4) begin
          timer_next = '0;
        end else if (timer_reg == TMR_MAX) begin
          state_next = STEER;
        end else begin
          timer_next = timer_reg + 26'd1;
        end
      end
      STEER: begin
        if (sum_lt_min) begin
          state_next = IDLE;
        end else if (diff_gt_15_16) begin
          state_next = WAIT;
          timer_next = '0;
        end
      end
      default: begin
        state_next = IDLE;
        timer_next = '0;
      end
    endcase
  end

  assign bus.en_steer  = en_steer_reg;
  assign bus.rider_off = rider_off_reg;

endmodule

// File: doc/rider_steer_en.md
RIDER_STEER_EN -- requirements
Module: rider_steer_en

Interface
REQ-001 Parameter FAST_SIM, default 0, meaning: 1 shortens the balance timer for simulation.
REQ-002 Parameter MIN_RIDER_WT, default 12'h200, meaning: summed-load threshold above which a rider is present.
REQ-003 Parameter WT_HYSTERESIS, default 12'h040, meaning: rider-leave threshold is MIN_RIDER_WT - WT_HYSTERESIS.
REQ-004 clk  input  1  system clock; all state changes on its rising edge.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 lft_ld  input  12  left load-cell reading (unsigned), held between updates by the A2D interface.
REQ-007 rght_ld  input  12  right load-cell reading (unsigned), held between updates by the A2D interface.
REQ-008 en_steer  output  1  steering enabled; registered.
REQ-009 rider_off  output  1  no rider on platform; registered.

Function
REQ-010 sum = lft_ld + rght_ld SHALL be computed at 13 bits, with no truncation.
REQ-011 diff = |lft_ld - rght_ld| SHALL be computed at 12 bits, unsigned magnitude.
REQ-012 sum_gt_min SHALL be sum > MIN_RIDER_WT (strict); sum_lt_min SHALL be sum < (MIN_RIDER_WT - WT_HYSTERESIS) (strict).
REQ-013 diff_gt_1_4 SHALL be diff > (sum >> 2); diff_gt_15_16 SHALL be diff > (sum - (sum >> 4)); both comparisons are 13-bit and strict.
REQ-014 The balance timer SHALL be a 26-bit up-counter; TMR_MAX = 2^26-1 when FAST_SIM=0 and 2^15-1 when FAST_SIM=1, i.e. ~1.34 s at 50 MHz.
REQ-015 The FSM SHALL have states IDLE, WAIT, STEER; outputs are Moore: rider_off = (state==IDLE), en_steer = (state==STEER).
REQ-016 IDLE: sum_gt_min -> WAIT with timer cleared to 0; otherwise stay in IDLE.
REQ-017 WAIT, priority order: sum_lt_min -> IDLE; else diff_gt_1_4 -> stay in WAIT, timer cleared to 0; else timer==TMR_MAX -> STEER; else stay in WAIT, timer +1.
REQ-018 STEER, priority order: sum_lt_min -> IDLE; else diff_gt_15_16 -> WAIT with timer cleared to 0; else stay in STEER.
REQ-019 The timer SHALL never wrap; it is cleared on every entry to WAIT and it is not advanced outside WAIT.
REQ-020 Latency: en_steer SHALL assert exactly TMR_MAX+1 cycles after the first WAIT cycle, given uninterrupted balance and weight.
REQ-021 sum between the two thresholds SHALL hold the current state (hysteresis band); sum == MIN_RIDER_WT SHALL NOT leave IDLE.
REQ-022 diff == sum>>2 exactly SHALL NOT clear the timer; diff == sum - (sum>>4) exactly SHALL NOT leave STEER.
REQ-023 When a weight-loss condition and a balance condition are true at the same time, the weight-loss condition SHALL win.
REQ-024 en_steer and rider_off SHALL never both be 1; outputs change only on a clock edge after a state change.

Reset
REQ-025 rst=1 at a clock edge SHALL force state=IDLE, timer=0, rider_off=1, en_steer=0 on that edge; the reset overrides every other condition, including a reset asserted mid-WAIT or mid-STEER.
REQ-026 The first transition after reset SHALL be evaluated on the first edge with rst=0.

Verification (FAST_SIM=1, TMR_MAX=32767)
REQ-027 Reset test: rst=1 for 2 cycles with lft=rght=12'h400 -> rider_off=1 and en_steer=0 throughout the reset; state is WAIT on the 1st edge after release.
REQ-028 Mount test: lft=12'h300, rght=12'h300 held -> WAIT, then en_steer=1 exactly 32768 cycles after the first WAIT cycle and not one cycle earlier.
REQ-029 Imbalance test: in WAIT at count 20000, set lft=12'h500, rght=12'h100 (diff 0x400 > 0x180) for 1 cycle, then restore balance -> timer restarts at 0 and en_steer rises 32768 cycles after the restore.
REQ-030 Hysteresis test: in STEER, set lft=rght=12'h0F0 (sum 0x1E0, inside the band) -> en_steer stays 1; then set lft=rght=12'h0D0 (sum 0x1A0 < 0x1C0) -> rider_off=1 on the next edge.
REQ-031 Step-off/priority test: in STEER, set lft=12'h1B0, rght=12'h000 (sum low and diff large) -> IDLE, not WAIT; rider_off=1, en_steer=0.
REQ-032 Boundary test: in IDLE, set lft=12'h100, rght=12'h100 (sum == 0x200) -> stays IDLE for 100 cycles; then set rght=12'h101 -> WAIT on the next edge.
